lcd_hd44780_responder: RTL and testbench

- Synthesizable responder for the HD44780-style 8-bit parallel LCD bus (E, RS, R_nW, data). It is the display end of the bus that our LCD controller drives.
- Decodes command and data writes, holds the DDRAM contents, address counter and mode flags, and models the busy flag.
- Answers busy-flag/AC reads and DDRAM reads.
- Used as an on-chip display mirror and as the self-checking target for controller benches.

---
 rtl/lcd_pkg.sv | 71 +++++++
 rtl/lcd_ddram.sv | 30 +++
 rtl/lcd_hd44780_responder.sv | 200 ++++++++++++++++++++
 tb/tb_lcd_hd44780_responder.sv | 202 ++++++++++++++++++++
 4 files changed

// File: rtl/lcd_pkg.sv
// Shared types, command masks and address-counter wrap helper for the
// HD44780-style display responder.
package lcd_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_BUSY  = 2'd1,
    ST_CLEAR = 2'd2
  } lcd_state_e;

  typedef enum logic [3:0] {
    CMD_NOP,
    CMD_CLEAR,
    CMD_HOME,
    CMD_ENTRY,
    CMD_DISP,
    CMD_SHIFT,
    CMD_FUNC,
    CMD_CGRAM,
    CMD_DDRAM
  } lcd_cmd_e;

  localparam logic [7:0] CMD_DDRAM_MASK = 8'h80;
  localparam logic [7:0] CMD_CGRAM_MASK = 8'h40;
  localparam logic [7:0] CMD_FUNC_MASK  = 8'h20;
  localparam logic [7:0] CMD_SHIFT_MASK = 8'h10;
  localparam logic [7:0] CMD_DISP_MASK  = 8'h08;
  localparam logic [7:0] CMD_ENTRY_MASK = 8'h04;
  localparam logic [7:0] CMD_HOME_MASK  = 8'h02;
  localparam logic [7:0] CMD_CLEAR_MASK = 8'h01;

  localparam logic [7:0] LCD_BLANK = 8'h20;

  localparam logic [6:0] LINE1_END_2L   = 7'h27;
  localparam logic [6:0] LINE2_START_2L = 7'h40;
  localparam logic [6:0] LINE2_END_2L   = 7'h67;
  localparam logic [6:0] LINE_END_1L    = 7'h4F;

  // The highest set bit selects the instruction.
  function automatic lcd_cmd_e decode_cmd(input logic [7:0] d);
    lcd_cmd_e c;
    if      ((d & CMD_DDRAM_MASK) != 8'h00) c = CMD_DDRAM;
    else if ((d & CMD_CGRAM_MASK) != 8'h00) c = CMD_CGRAM;
    else if ((d & CMD_FUNC_MASK)  != 8'h00) c = CMD_FUNC;
    else if ((d & CMD_SHIFT_MASK) != 8'h00) c = CMD_SHIFT;
    else if ((d & CMD_DISP_MASK)  != 8'h00) c = CMD_DISP;
    else if ((d & CMD_ENTRY_MASK) != 8'h00) c = CMD_ENTRY;
    else if ((d & CMD_HOME_MASK)  != 8'h00) c = CMD_HOME;
    else if ((d & CMD_CLEAR_MASK) != 8'h00) c = CMD_CLEAR;
    else                                    c = CMD_NOP;
    return c;
  endfunction

  // Out-of-range addresses simply wrap modulo 128.
  function automatic logic [6:0] ac_step(input logic [6:0] ac,
                                         input logic       inc,
                                         input logic       two_line);
    logic [6:0] n;
    if (two_line) begin
      if (inc) n = (ac == LINE1_END_2L) ? LINE2_START_2L :
                   (ac == LINE2_END_2L) ? 7'h00 : ac + 7'd1;
      else     n = (ac == LINE2_START_2L) ? LINE1_END_2L :
                   (ac == 7'h00) ? LINE2_END_2L : ac - 7'd1;
    end else begin
      if (inc) n = (ac == LINE_END_1L) ? 7'h00 : ac + 7'd1;
      else     n = (ac == 7'h00) ? LINE_END_1L : ac - 7'd1;
    end
    return n;
  endfunction

endpackage

// File: rtl/lcd_ddram.sv
// 128x8 display RAM: one write port, an async bus read port and a
// registered side read port that returns pre-write data on collisions.
module lcd_ddram (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       we_i,
  input  logic [6:0] waddr_i,
  input  logic [7:0] wdata_i,
  input  logic [6:0] raddr_i,
  output logic [7:0] rdata_o,
  input  logic [6:0] side_addr_i,
  output logic [7:0] side_data_o
);

  logic [7:0] mem_q [128];
  logic [7:0] side_q;

  always_ff @(posedge clk) begin
    if (we_i) mem_q[waddr_i] <= wdata_i;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) side_q <= 8'h00;
    else        side_q <= mem_q[side_addr_i];
  end

  assign rdata_o     = mem_q[raddr_i];
  assign side_data_o = side_q;

endmodule

// File: rtl/lcd_hd44780_responder.sv
// Display end of the HD44780-style 8-bit bus: decodes strobes committed on
// the falling edge of E, holds DDRAM/AC/mode flags and models the busy flag.
module lcd_hd44780_responder
  import lcd_pkg::*;
#(
  parameter int CMD_CYCLES = 37,
  parameter int CLR_CYCLES = 1520,
  parameter int CNT_W      = 16
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       E,
  input  logic       RS,
  input  logic       R_nW,
  input  logic [7:0] data_in,
  output logic [7:0] data_out,
  output logic       data_oe,
  output logic       busy,
  output logic [6:0] addr_cnt,
  output logic       disp_on,
  output logic       cursor_on,
  output logic       blink_on,
  output logic       entry_inc,
  output logic       entry_shift,
  output logic       func_8bit,
  output logic       func_2line,
  output logic       func_font,
  output logic       overrun,
  input  logic [6:0] rd_addr,
  output logic [7:0] rd_data
);

  // Counter is loaded with duration-1 so the busy window is exactly the duration.
  localparam logic [CNT_W-1:0] CMD_LOAD = CNT_W'(CMD_CYCLES - 1);
  localparam logic [CNT_W-1:0] CLR_LOAD = CNT_W'(CLR_CYCLES - 1);

  lcd_state_e       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [6:0]       clr_idx_q, clr_idx_d;
  logic [6:0]       ac_q, ac_d;
  logic             e_q;
  logic             disp_q, disp_d, cur_q, cur_d, blink_q, blink_d;
  logic             inc_q, inc_d, shift_q, shift_d;
  logic             f8_q, f8_d, f2l_q, f2l_d, ffont_q, ffont_d;
  logic             overrun_q, overrun_d;

  logic             commit;
  logic             mem_we;
  logic [6:0]       mem_waddr;
  logic [7:0]       mem_wdata;
  logic [7:0]       mem_rdata;

  assign commit = e_q & ~E;

  lcd_ddram u_ddram (
    .clk         (clk),
    .rst_n       (reset),
    .we_i        (mem_we),
    .waddr_i     (mem_waddr),
    .wdata_i     (mem_wdata),
    .raddr_i     (ac_q),
    .rdata_o     (mem_rdata),
    .side_addr_i (rd_addr),
    .side_data_o (rd_data)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= ST_IDLE;
      cnt_q     <= '0;
      clr_idx_q <= 7'h00;
      ac_q      <= 7'h00;
      e_q       <= 1'b0;
      disp_q    <= 1'b0;
      cur_q     <= 1'b0;
      blink_q   <= 1'b0;
      inc_q     <= 1'b1;
      shift_q   <= 1'b0;
      f8_q      <= 1'b0;
      f2l_q     <= 1'b0;
      ffont_q   <= 1'b0;
      overrun_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      clr_idx_q <= clr_idx_d;
      ac_q      <= ac_d;
      e_q       <= E;
      disp_q    <= disp_d;
      cur_q     <= cur_d;
      blink_q   <= blink_d;
      inc_q     <= inc_d;
      shift_q   <= shift_d;
      f8_q      <= f8_d;
      f2l_q     <= f2l_d;
      ffont_q   <= ffont_d;
      overrun_q <= overrun_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    clr_idx_d = clr_idx_q;
    ac_d      = ac_q;
    disp_d    = disp_q;
    cur_d     = cur_q;
    blink_d   = blink_q;
    inc_d     = inc_q;
    shift_d   = shift_q;
    f8_d      = f8_q;
    f2l_d     = f2l_q;
    ffont_d   = ffont_q;
    overrun_d = overrun_q;
    mem_we    = 1'b0;
    mem_waddr = ac_q;
    mem_wdata = data_in;

    case (state_q)
      ST_IDLE: begin
        if (commit) begin
          if (RS) begin
            // Data read and data write both advance AC and take a command slot.
            mem_we  = ~R_nW;
            ac_d    = ac_step(ac_q, inc_q, f2l_q);
            state_d = ST_BUSY;
            cnt_d   = CMD_LOAD;
          end else if (!R_nW) begin
            state_d = ST_BUSY;
            cnt_d   = CMD_LOAD;
            case (decode_cmd(data_in))
              CMD_DDRAM: ac_d = data_in[6:0];
              CMD_CGRAM: ;
              CMD_FUNC: begin
                f8_d    = data_in[4];
                f2l_d   = data_in[3];
                ffont_d = data_in[2];
              end
              CMD_SHIFT: if (!data_in[3]) ac_d = ac_step(ac_q, data_in[2], f2l_q);
              CMD_DISP: begin
                disp_d  = data_in[2];
                cur_d   = data_in[1];
                blink_d = data_in[0];
              end
              CMD_ENTRY: begin
                inc_d   = data_in[1];
                shift_d = data_in[0];
              end
              CMD_HOME: begin
                ac_d  = 7'h00;
                cnt_d = CLR_LOAD;
              end
              CMD_CLEAR: begin
                ac_d      = 7'h00;
                inc_d     = 1'b1;
                clr_idx_d = 7'h00;
                cnt_d     = CLR_LOAD;
                state_d   = ST_CLEAR;
              end
              default: begin
                state_d = ST_IDLE;
                cnt_d   = cnt_q;
              end
            endcase
          end
        end
      end
      ST_BUSY: begin
        if (cnt_q == '0) state_d = ST_IDLE;
        else             cnt_d   = cnt_q - 1'b1;
      end
      ST_CLEAR: begin
        mem_we    = 1'b1;
        mem_waddr = clr_idx_q;
        mem_wdata = LCD_BLANK;
        clr_idx_d = clr_idx_q + 7'd1;
        cnt_d     = cnt_q - 1'b1;
        if (clr_idx_q == 7'h7F) state_d = ST_BUSY;
      end
      default: state_d = ST_IDLE;
    endcase

    if (commit && state_q != ST_IDLE && !R_nW) overrun_d = 1'b1;
  end

  assign busy        = (state_q != ST_IDLE);
  assign data_oe     = E & R_nW;
  assign data_out    = !data_oe ? 8'h00 : (RS ? mem_rdata : {busy, ac_q});
  assign addr_cnt    = ac_q;
  assign disp_on     = disp_q;
  assign cursor_on   = cur_q;
  assign blink_on    = blink_q;
  assign entry_inc   = inc_q;
  assign entry_shift = shift_q;
  assign func_8bit   = f8_q;
  assign func_2line  = f2l_q;
  assign func_font   = ffont_q;
  assign overrun     = overrun_q;

endmodule

// File: tb/tb_lcd_hd44780_responder.sv
// Directed bench for the HD44780 responder: a strobe table with hand-computed
// busy lengths, AC values and DDRAM contents, plus corner-case sequences.
module tb_lcd_hd44780_responder;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       E = 1'b0, RS = 1'b0, R_nW = 1'b0;
  logic [7:0] data_in = 8'h00;
  logic [6:0] rd_addr = 7'h00;
  logic [7:0] data_out, rd_data;
  logic       data_oe, busy;
  logic [6:0] addr_cnt;
  logic       disp_on, cursor_on, blink_on, entry_inc, entry_shift;
  logic       func_8bit, func_2line, func_font, overrun;

  int checks = 0;
  int failures = 0;

  lcd_hd44780_responder #(.CMD_CYCLES(37), .CLR_CYCLES(1520), .CNT_W(16)) dut (
    .clk(clk), .reset(reset), .E(E), .RS(RS), .R_nW(R_nW), .data_in(data_in),
    .data_out(data_out), .data_oe(data_oe), .busy(busy), .addr_cnt(addr_cnt),
    .disp_on(disp_on), .cursor_on(cursor_on), .blink_on(blink_on),
    .entry_inc(entry_inc), .entry_shift(entry_shift), .func_8bit(func_8bit),
    .func_2line(func_2line), .func_font(func_font), .overrun(overrun),
    .rd_addr(rd_addr), .rd_data(rd_data)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       rs;
    logic [7:0] d;
    int         exp_busy;
    logic [6:0] exp_ac;
    logic       chk_en;
    logic [6:0] chk_addr;
    logic [7:0] chk_data;
  } vec_t;

  vec_t vecs[20];

  function automatic vec_t mk(logic rs, logic [7:0] d, int nb, logic [6:0] ac,
                              logic ce, logic [6:0] ca, logic [7:0] cd);
    vec_t v;
    v.rs = rs; v.d = d; v.exp_busy = nb; v.exp_ac = ac;
    v.chk_en = ce; v.chk_addr = ca; v.chk_data = cd;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic strobe(input logic rs, input logic rnw, input logic [7:0] d);
    @(posedge clk); #1; E = 1'b1; RS = rs; R_nW = rnw; data_in = d;
    @(posedge clk); #1; E = 1'b0;
    @(posedge clk); #1; RS = 1'b0; R_nW = 1'b0; data_in = 8'h00;
  endtask

  task automatic wait_idle(output int n);
    n = 0;
    @(negedge clk);
    while (busy === 1'b1 && n < 5000) begin
      n++;
      @(negedge clk);
    end
    if (n >= 5000) begin
      checks++;
      failures++;
      $display("FAIL busy_timeout: busy still high after %0d cycles", n);
    end
  endtask

  task automatic rd_check(input string name, input logic [6:0] a, input logic [7:0] exp);
    @(posedge clk); #1; rd_addr = a;
    @(posedge clk);
    @(negedge clk);
    chk(name, {24'h0, rd_data}, {24'h0, exp});
  endtask

  initial begin
    int n;

    vecs[0]  = mk(0, 8'h3C, 37,   7'h00, 0, 7'h00, 8'h00);
    vecs[1]  = mk(0, 8'h0F, 37,   7'h00, 0, 7'h00, 8'h00);
    vecs[2]  = mk(0, 8'h01, 1520, 7'h00, 1, 7'h00, 8'h20);
    vecs[3]  = mk(0, 8'h06, 37,   7'h00, 1, 7'h3F, 8'h20);
    vecs[4]  = mk(1, 8'h48, 37,   7'h01, 1, 7'h7F, 8'h20);
    vecs[5]  = mk(1, 8'h45, 37,   7'h02, 0, 7'h00, 8'h00);
    vecs[6]  = mk(1, 8'h4C, 37,   7'h03, 1, 7'h00, 8'h48);
    vecs[7]  = mk(1, 8'h4C, 37,   7'h04, 1, 7'h01, 8'h45);
    vecs[8]  = mk(1, 8'h4F, 37,   7'h05, 1, 7'h04, 8'h4F);
    vecs[9]  = mk(0, 8'hA7, 37,   7'h27, 1, 7'h02, 8'h4C);
    vecs[10] = mk(1, 8'h41, 37,   7'h40, 1, 7'h27, 8'h41);
    vecs[11] = mk(0, 8'h80, 37,   7'h00, 1, 7'h03, 8'h4C);
    vecs[12] = mk(0, 8'h04, 37,   7'h00, 0, 7'h00, 8'h00);
    vecs[13] = mk(1, 8'h5A, 37,   7'h67, 1, 7'h00, 8'h5A);
    vecs[14] = mk(0, 8'h02, 1520, 7'h00, 1, 7'h40, 8'h20);
    vecs[15] = mk(0, 8'h00, 0,    7'h00, 0, 7'h00, 8'h00);
    vecs[16] = mk(0, 8'h14, 37,   7'h01, 0, 7'h00, 8'h00);
    vecs[17] = mk(0, 8'h10, 37,   7'h00, 0, 7'h00, 8'h00);
    vecs[18] = mk(0, 8'h10, 37,   7'h67, 0, 7'h00, 8'h00);
    vecs[19] = mk(0, 8'h06, 37,   7'h67, 0, 7'h00, 8'h00);

    // Reset state
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_busy", busy, 0);
    chk("rst_ac", addr_cnt, 0);
    chk("rst_flags", {disp_on, cursor_on, blink_on, entry_inc, entry_shift,
                      func_8bit, func_2line, func_font, overrun}, 9'b000100000);
    chk("rst_bus", {data_oe, data_out}, 0);
    chk("rst_rd_data", rd_data, 0);
    @(posedge clk); #1; reset = 1'b1;

    for (int i = 0; i < 20; i++) begin
      strobe(vecs[i].rs, 1'b0, vecs[i].d);
      wait_idle(n);
      chk($sformatf("v%0d_busy_len", i), n, vecs[i].exp_busy);
      chk($sformatf("v%0d_ac", i), addr_cnt, vecs[i].exp_ac);
      if (vecs[i].chk_en) rd_check($sformatf("v%0d_ddram", i), vecs[i].chk_addr, vecs[i].chk_data);
    end
    chk("init_func", {func_8bit, func_2line, func_font}, 3'b111);
    chk("init_disp", {disp_on, cursor_on, blink_on}, 3'b111);
    chk("init_entry", {entry_inc, entry_shift}, 2'b10);
    chk("no_overrun_yet", overrun, 0);

    // Bus data read returns DDRAM[AC] and advances AC
    strobe(0, 0, 8'h80); wait_idle(n);
    strobe(1, 0, 8'h33); wait_idle(n);
    strobe(0, 0, 8'h80); wait_idle(n);
    @(posedge clk); #1; E = 1'b1; RS = 1'b1; R_nW = 1'b1;
    @(negedge clk);
    chk("data_read_bus", {data_oe, data_out}, 9'h133);
    @(posedge clk); #1; E = 1'b0;
    @(posedge clk); #1; RS = 1'b0; R_nW = 1'b0;
    wait_idle(n);
    chk("data_read_busy_len", n, 37);
    chk("data_read_ac", addr_cnt, 1);

    // Clear, write while busy, busy-flag read at cycle 10
    strobe(0, 0, 8'h01);
    strobe(1, 0, 8'h48);
    @(negedge clk);
    chk("overrun_set", overrun, 1);
    chk("overrun_ac_unchanged", addr_cnt, 0);
    repeat (6) @(posedge clk);
    #1; E = 1'b1; RS = 1'b0; R_nW = 1'b1;
    @(negedge clk);
    chk("bf_read_during_clear", {data_oe, data_out}, 9'h180);
    @(posedge clk); #1; E = 1'b0;
    @(posedge clk); #1; R_nW = 1'b0;
    wait_idle(n);
    @(posedge clk); #1; E = 1'b1; R_nW = 1'b1;
    @(negedge clk);
    chk("bf_read_after_clear", {data_oe, data_out}, 9'h100);
    @(posedge clk); #1; E = 1'b0;
    @(posedge clk); #1; R_nW = 1'b0;
    wait_idle(n);
    chk("bf_read_no_busy", n, 0);
    @(negedge clk);
    chk("bus_idle", {data_oe, data_out}, 0);
    rd_check("overrun_ddram0", 7'h00, 8'h20);
    chk("overrun_sticky", overrun, 1);

    // Reset in the middle of a clear
    strobe(0, 0, 8'hBC); wait_idle(n);
    strobe(1, 0, 8'h77); wait_idle(n);
    strobe(0, 0, 8'h01);
    repeat (50) @(posedge clk);
    #1; reset = 1'b0;
    @(negedge clk);
    chk("midclr_busy", busy, 0);
    chk("midclr_ac", addr_cnt, 0);
    chk("midclr_flags", {disp_on, cursor_on, blink_on, entry_inc, entry_shift,
                         func_8bit, func_2line, func_font, overrun}, 9'b000100000);
    @(posedge clk); #1; reset = 1'b1;
    rd_check("midclr_ddram60_kept", 7'd60, 8'h77);
    rd_check("midclr_ddram10_blank", 7'd10, 8'h20);
    @(negedge clk);
    chk("midclr_still_idle", busy, 0);

    // 1-line wrap after reset (func_2line = 0)
    strobe(0, 0, 8'hCF); wait_idle(n);
    chk("l1_set_ac", addr_cnt, 7'h4F);
    strobe(1, 0, 8'h11); wait_idle(n);
    chk("l1_inc_wrap", addr_cnt, 7'h00);
    strobe(0, 0, 8'h04); wait_idle(n);
    strobe(1, 0, 8'h22); wait_idle(n);
    chk("l1_dec_wrap", addr_cnt, 7'h4F);
    rd_check("l1_ddram4f", 7'h4F, 8'h11);
    rd_check("l1_ddram00", 7'h00, 8'h22);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
